// File: rtl/pmu_counter_bank.sv
// -----------------------------------------------------------------------------
// pmu_counter_bank
//
// Core-side owner of the PMU event counters and PMU configuration registers.
// This block answers read and write requests from the AXI-side PMU bridge. The
// bridge uses a four-phase enable/valid handshake. The enables arrive
// asynchronously to clk_i. Address and data are held stable while their enable
// is high, so only the enables need a synchronizer.
//
// Ports:
//   clk_i                  core clock
//   rst_i                  synchronous active-high reset
//   events_i               per-cycle event pulses, one bit per counter
//   counter_read_enable    read request level (async)
//   counter_read_address   word index of the read
//   counter_read_valid     read acknowledge level
//   counter_read_data      read result, held after valid drops
//   counter_write_enable   write request level (async)
//   counter_write_address  word index of the write
//   counter_write_data     write value
//   counter_write_valid    write acknowledge level
//
// Word map: [0 .. N_CONF_REGS-1] conf regs, then one word per counter. All
// other words read as zero and ignore writes, but they are still acknowledged.
// Conf reg 0: bit0 global_enable, bit1 clear_all (self-clearing, reads 0),
// bits 63:2 R/W scratch.
// -----------------------------------------------------------------------------
module pmu_counter_bank #(
    parameter int unsigned N_COUNTERS  = 23,
    parameter int unsigned N_CONF_REGS = 1,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_COUNTERS-1:0] events_i,
    input  logic                  counter_read_enable,
    input  logic [ADDR_WIDTH-1:0] counter_read_address,
    output logic                  counter_read_valid,
    output logic [DATA_WIDTH-1:0] counter_read_data,
    input  logic                  counter_write_enable,
    input  logic [ADDR_WIDTH-1:0] counter_write_address,
    input  logic [DATA_WIDTH-1:0] counter_write_data,
    output logic                  counter_write_valid
);

    typedef enum logic [0:0] {
        StIdle,
        StAck
    } hs_state_e;

    // Conf reg 0 never stores clear_all, so a read of it always returns 0.
    localparam logic [DATA_WIDTH-1:0] CONF0_WMASK = ~(DATA_WIDTH'(2));
    localparam logic [DATA_WIDTH-1:0] CNT_ONE     = DATA_WIDTH'(1);

    // -------------------------------------------------------------------------
    // Enable synchronizers (2 flops each)
    // -------------------------------------------------------------------------
    logic [1:0] r_rd_sync;
    logic [1:0] r_wr_sync;
    logic       w_rd_en_s;
    logic       w_wr_en_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_sync <= 2'b00;
            r_wr_sync <= 2'b00;
        end else begin
            r_rd_sync <= {r_rd_sync[0], counter_read_enable};
            r_wr_sync <= {r_wr_sync[0], counter_write_enable};
        end
    end

    assign w_rd_en_s = r_rd_sync[1];
    assign w_wr_en_s = r_wr_sync[1];

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_conf [N_CONF_REGS];
    logic [DATA_WIDTH-1:0] r_cnt  [N_COUNTERS];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  w_global_en;

    assign w_global_en = r_conf[0][0];

    // -------------------------------------------------------------------------
    // Read FSM
    // -------------------------------------------------------------------------
    hs_state_e r_rd_state;
    hs_state_e w_rd_state_nxt;
    logic      w_rd_latch;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_state <= StIdle;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        unique case (r_rd_state)
            StIdle: if (w_rd_en_s)  w_rd_state_nxt = StAck;
            StAck:  if (!w_rd_en_s) w_rd_state_nxt = StIdle;
            default: w_rd_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        counter_read_valid = (r_rd_state == StAck);
        w_rd_latch         = (r_rd_state == StIdle) && w_rd_en_s;
    end

    // -------------------------------------------------------------------------
    // Read mux: registered values only, so a read latching on the same edge as
    // a write to the same word returns the pre-write value.
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_rd_value;

    always_comb begin
        w_rd_value = '0;
        for (int unsigned j = 0; j < N_CONF_REGS; j++) begin
            if (counter_read_address == ADDR_WIDTH'(j)) begin
                w_rd_value = r_conf[j];
            end
        end
        for (int unsigned i = 0; i < N_COUNTERS; i++) begin
            if (counter_read_address == ADDR_WIDTH'(N_CONF_REGS + i)) begin
                w_rd_value = r_cnt[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_data <= '0;
        end else if (w_rd_latch) begin
            r_rd_data <= w_rd_value;
        end
    end

    assign counter_read_data = r_rd_data;

    // -------------------------------------------------------------------------
    // Write FSM
    // -------------------------------------------------------------------------
    hs_state_e r_wr_state;
    hs_state_e w_wr_state_nxt;
    logic      w_wr_commit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_state <= StIdle;
        end else begin
            r_wr_state <= w_wr_state_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        unique case (r_wr_state)
            StIdle: if (w_wr_en_s)  w_wr_state_nxt = StAck;
            StAck:  if (!w_wr_en_s) w_wr_state_nxt = StIdle;
            default: w_wr_state_nxt = StIdle;
        endcase
    end

    // The commit happens only on the IDLE->ACK edge. A held enable therefore
    // writes exactly once.
    always_comb begin
        counter_write_valid = (r_wr_state == StAck);
        w_wr_commit         = (r_wr_state == StIdle) && w_wr_en_s;
    end

    // -------------------------------------------------------------------------
    // Write decode
    // -------------------------------------------------------------------------
    logic [N_CONF_REGS-1:0] w_conf_we;
    logic [N_COUNTERS-1:0]  w_cnt_we;
    logic                   w_clear_all;

    always_comb begin
        w_conf_we = '0;
        w_cnt_we  = '0;
        for (int unsigned j = 0; j < N_CONF_REGS; j++) begin
            w_conf_we[j] = w_wr_commit && (counter_write_address == ADDR_WIDTH'(j));
        end
        for (int unsigned i = 0; i < N_COUNTERS; i++) begin
            w_cnt_we[i] = w_wr_commit &&
                          (counter_write_address == ADDR_WIDTH'(N_CONF_REGS + i));
        end
    end

    assign w_clear_all = w_conf_we[0] && counter_write_data[1];

    // -------------------------------------------------------------------------
    // Configuration registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        for (int unsigned j = 0; j < N_CONF_REGS; j++) begin
            if (rst_i) begin
                r_conf[j] <= '0;
            end else if (w_conf_we[j]) begin
                r_conf[j] <= (j == 0) ? (counter_write_data & CONF0_WMASK)
                                      : counter_write_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Event counters. Priority: clear_all > direct write > event increment, so
    // an event on a write or clear edge is lost. Wraps modulo 2^DATA_WIDTH.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < N_COUNTERS; i++) begin
            if (rst_i) begin
                r_cnt[i] <= '0;
            end else if (w_clear_all) begin
                r_cnt[i] <= '0;
            end else if (w_cnt_we[i]) begin
                r_cnt[i] <= counter_write_data;
            end else if (w_global_en && events_i[i]) begin
                r_cnt[i] <= r_cnt[i] + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pmu_counter_bank.sv
// Directed bench for pmu_counter_bank: handshake latency, counting, wrap,
// write/event priority, clear_all, unmapped words and mid-transaction reset.
module tb_pmu_counter_bank;

    localparam int unsigned NC = 23;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] events;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pmu_counter_bank dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .events_i              (events),
        .counter_read_enable   (rd_en),
        .counter_read_address  (rd_addr),
        .counter_read_valid    (rd_valid),
        .counter_read_data     (rd_data),
        .counter_write_enable  (wr_en),
        .counter_write_address (wr_addr),
        .counter_write_data    (wr_data),
        .counter_write_valid   (wr_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts edges until the selected valid reaches lvl; gives up after 20.
    task automatic wait_valid(input bit is_wr, input logic lvl, output int edges);
        edges = 0;
        while (((is_wr ? wr_valid : rd_valid) !== lvl) && (edges < 20)) begin
            tick();
            edges++;
        end
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] addr,
                           input logic [DW-1:0] exp);
        int n;
        rd_addr = addr;
        rd_en   = 1'b1;
        wait_valid(1'b0, 1'b1, n);
        check({tag, " rise"}, DW'(n), DW'(3));
        check({tag, " data"}, rd_data, exp);
        rd_en = 1'b0;
        wait_valid(1'b0, 1'b0, n);
        check({tag, " fall"}, DW'(n), DW'(3));
        check({tag, " hold"}, rd_data, exp);
    endtask

    task automatic write_start(input string tag, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data);
        int n;
        wr_addr = addr;
        wr_data = data;
        wr_en   = 1'b1;
        wait_valid(1'b1, 1'b1, n);
        check({tag, " rise"}, DW'(n), DW'(3));
    endtask

    task automatic write_end(input string tag);
        int n;
        wr_en = 1'b0;
        wait_valid(1'b1, 1'b0, n);
        check({tag, " fall"}, DW'(n), DW'(3));
    endtask

    task automatic do_write(input string tag, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data);
        write_start(tag, addr, data);
        write_end(tag);
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        events  = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        tick();
        tick();
        check("reset rd_valid", DW'(rd_valid), DW'(0));
        check("reset wr_valid", DW'(wr_valid), DW'(0));
        check("reset rd_data", rd_data, DW'(0));
        rst = 1'b0;

        // Counting disabled: events must not count
        events = '1;
        repeat (10) tick();
        events = '0;
        do_read("t1 cnt0", 8'd1, 64'd0);
        do_read("t1 conf0", 8'd0, 64'd0);

        // Enable counting, 100 events on counter 0
        do_write("t2 conf0", 8'd0, 64'd1);
        events[0] = 1'b1;
        repeat (100) tick();
        events[0] = 1'b0;
        do_read("t2 cnt0", 8'd1, 64'd100);
        do_read("t2 conf0", 8'd0, 64'd1);

        // Write beats the event on the same edge, then wrap
        events[2] = 1'b1;
        write_start("t3 wr", 8'd3, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        events[2] = 1'b0;
        write_end("t3 wr");
        do_read("t3 ff", 8'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        events[2] = 1'b1;
        tick();
        events[2] = 1'b0;
        do_read("t3 wrap", 8'd3, 64'd0);
        do_read("t3 cnt0", 8'd1, 64'd100);

        // Read and write the same word on the same edge: read sees old value
        rd_addr = 8'd2;
        wr_addr = 8'd2;
        wr_data = 64'h77;
        rd_en   = 1'b1;
        wr_en   = 1'b1;
        wait_valid(1'b0, 1'b1, n);
        check("rw rise", DW'(n), DW'(3));
        check("rw wr_valid", DW'(wr_valid), DW'(1));
        check("rw old data", rd_data, 64'd0);
        rd_en = 1'b0;
        wr_en = 1'b0;
        wait_valid(1'b0, 1'b0, n);
        check("rw fall", DW'(n), DW'(3));
        check("rw wr_valid low", DW'(wr_valid), DW'(0));
        do_read("rw new", 8'd2, 64'h77);

        // clear_all
        do_write("t4 clr", 8'd0, 64'h3);
        do_read("t4 cnt0", 8'd1, 64'd0);
        do_read("t4 cnt1", 8'd2, 64'd0);
        do_read("t4 conf0", 8'd0, 64'd1);
        events[0] = 1'b1;
        repeat (5) tick();
        events[0] = 1'b0;
        do_read("t4 resume", 8'd1, 64'd5);

        // Unmapped word
        do_read("t5 rd200", 8'd200, 64'd0);
        do_write("t5 wr200", 8'd200, 64'h55);
        do_read("t5 rd200b", 8'd200, 64'd0);
        do_read("t5 conf0", 8'd0, 64'd1);
        do_read("t5 cnt0", 8'd1, 64'd5);

        // Reset while read is acknowledged with enable still high
        rd_addr = 8'd1;
        rd_en   = 1'b1;
        wait_valid(1'b0, 1'b1, n);
        check("t6 rise", DW'(n), DW'(3));
        check("t6 data", rd_data, 64'd5);
        rst = 1'b1;
        tick();
        check("t6 rst valid", DW'(rd_valid), DW'(0));
        check("t6 rst data", rd_data, 64'd0);
        rst = 1'b0;
        wait_valid(1'b0, 1'b1, n);
        check("t6 re-rise", DW'(n), DW'(3));
        check("t6 re-data", rd_data, 64'd0);
        rd_en = 1'b0;
        wait_valid(1'b0, 1'b0, n);
        check("t6 fall", DW'(n), DW'(3));
        do_read("t6 conf0", 8'd0, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pmu_counter_bank.md
Name: pmu_counter_bank

Overview:
- Core-side responder for the PMU counter access interface. It owns the event counters and the PMU configuration register.
- It answers read and write requests issued from the AXI clock domain by the PMU AXI bridge, using a four-phase enable/valid handshake.
- Enable inputs are asynchronous to clk_i and are synchronized internally. Address and write-data inputs are stable whenever their enable is high.

Parameters:
- N_COUNTERS, 23, number of 64-bit event counters.
- N_CONF_REGS, 1, number of configuration registers; these occupy the low word addresses.
- ADDR_WIDTH, 8, width of the word-index address.
- DATA_WIDTH, 64, width of counter, configuration and data buses.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous, active-high reset
- events_i  in  N_COUNTERS  per-cycle event pulses, one bit per counter
- counter_read_enable  in  1  read request level (async to clk_i)
- counter_read_address  in  ADDR_WIDTH  word index of the read
- counter_read_valid  out  1  read acknowledge level
- counter_read_data  out  DATA_WIDTH  read result; stable while counter_read_valid=1
- counter_write_enable  in  1  write request level (async to clk_i)
- counter_write_address  in  ADDR_WIDTH  word index of the write
- counter_write_data  in  DATA_WIDTH  write value
- counter_write_valid  out  1  write acknowledge level

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - all counters, conf regs, counter_read_valid, counter_write_valid, counter_read_data and synchronizer flops go to 0;
  - both FSMs go to IDLE;
  - a reset mid-transaction drops valid immediately.
- Synchronization: each enable passes through a 2-flop synchronizer (en_s); only en_s is used.
- Address map:
  - word 0..N_CONF_REGS-1: conf regs;
  - word N_CONF_REGS..N_CONF_REGS+N_COUNTERS-1: counter (addr-N_CONF_REGS);
  - any other address reads 0, a write to it is dropped, and it is still acknowledged.
- Conf reg 0 layout:
  - bit0 global_enable;
  - bit1 clear_all, self-clearing, always reads 0;
  - bits 63:2 are R/W scratch.
- Read FSM, states IDLE, ACK:
  - IDLE->ACK when en_s=1: same edge latches the addressed value into counter_read_data and sets valid=1.
  - ACK->IDLE when en_s=0: same edge clears valid; counter_read_data holds its value.
- Write FSM, states IDLE, ACK:
  - IDLE->ACK when en_s=1: same edge commits the write exactly once and sets valid=1.
  - ACK->IDLE when en_s=0: clears valid.
  - A write is never repeated while in ACK.
- Latency: valid rises on the 3rd clk_i edge at which the enable is sampled high (2 sync edges + 1). Valid falls likewise 3 edges after the enable is sampled low.
- Counting: counter i increments by 1 on each edge where global_enable=1 and events_i[i]=1.
  - 64-bit modulo arithmetic: all-ones wraps to 0; no saturation and no overflow flag.
- Simultaneous events:
  - counter write vs. event on the same edge: the written value is stored and the event is lost;
  - clear_all write: all counters read 0 on the next edge; events on that edge are lost; the other conf bits are written as given;
  - read and write FSMs are independent and may both be in ACK;
  - a read latching on the same edge as a write to the same word returns the pre-write value.
- Read data latch is the registered value at the latch edge; counting continues afterwards.
- Enable dropping before valid rises is treated as a completed request:
  - the FSM still reaches ACK if en_s was seen high, then returns to IDLE.

Test Plan:
- Reset, conf0=0, pulse events_i all-ones 10 cycles, read word 1 -> valid rises 3 edges after enable; data=0.
- Write conf0=1, hold events_i[0]=1 for 100 cycles, read word 1 -> data=100; write and read valid each follow the 4-phase handshake, one ack per request.
- Write counter 2 (word 3)=0xFFFF_FFFF_FFFF_FFFE with events_i[2] held high -> reads 0xFFFF_FFFF_FFFF_FFFF then wraps to 0; a same-edge write beats the event.
- Write conf0=0x3 -> all counters read 0, conf0 reads 0x1, counting resumes.
- Read word 200 and write word 200=0x55 -> read data=0, no state changes, both acked.
- Assert rst_i while counter_read_valid=1 with enable still high -> valid=0 at the reset edge, then a new ack 3 edges after reset deasserts.
